// File: rtl/timer_bcd_countdown_if.sv
// Timer-control interface between the keypad/mode logic (master) and the BCD countdown (slave).
interface timer_bcd_countdown_if;
    logic [3:0] D;
    logic       load_n;
    logic       pgt_1Hz;
    logic       enable_n;
    logic       clear_n;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       zero;
    logic       done;

    modport master (
        output D, load_n, pgt_1Hz, enable_n, clear_n,
        input  sec_ones, sec_tens, min_ones, min_tens, zero, done
    );

    modport slave (
        input  D, load_n, pgt_1Hz, enable_n, clear_n,
        output sec_ones, sec_tens, min_ones, min_tens, zero, done
    );
endinterface

// File: rtl/timer_bcd_countdown.sv
// Four-digit BCD mm:ss cooking timer: keypad entry shifts digits in, run mode counts down at 1 Hz.
// Optional TIMER_ENTRY_LOCK_EN: entry loads are ignored once min_tens is non-zero.
module timer_bcd_countdown #(
    parameter int unsigned SEC_TENS_MAX = 5,
    parameter int unsigned DIGIT_MAX    = 9
) (
    input logic                 clock_100Hz,
    input logic                 reset,
    timer_bcd_countdown_if.slave bus
);
    localparam logic [3:0] SecTensMax = 4'(SEC_TENS_MAX);
    localparam logic [3:0] DigitMax   = 4'(DIGIT_MAX);

    logic       p_q;
    logic [3:0] sec_ones_q, sec_tens_q, min_ones_q, min_tens_q;
    logic       done_q;

    logic       tick, zero, entry_open, load_ok;
    logic       borrow_st, borrow_mo, borrow_mt;
    logic [3:0] dec_sec_ones, dec_sec_tens, dec_min_ones, dec_min_tens;
    logic       dec_zero;

    // pgt_1Hz is only a data strobe; its rising edge is detected in the 100 Hz domain.
    assign tick = bus.pgt_1Hz & ~p_q;
    assign zero = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) &&
                  (min_ones_q == 4'd0) && (min_tens_q == 4'd0);

`ifdef TIMER_ENTRY_LOCK_EN
    assign entry_open = (min_tens_q == 4'd0);
`else
    assign entry_open = 1'b1;
`endif

    assign load_ok = ~bus.load_n && (bus.D <= DigitMax) && entry_open;

    // BCD borrow chain; sec_tens above SecTensMax just decrements, it is never normalized.
    assign borrow_st    = (sec_ones_q == 4'd0);
    assign borrow_mo    = borrow_st && (sec_tens_q == 4'd0);
    assign borrow_mt    = borrow_mo && (min_ones_q == 4'd0);
    assign dec_sec_ones = borrow_st ? DigitMax : sec_ones_q - 4'd1;
    assign dec_sec_tens = !borrow_st ? sec_tens_q :
                          (sec_tens_q == 4'd0) ? SecTensMax : sec_tens_q - 4'd1;
    assign dec_min_ones = !borrow_mo ? min_ones_q :
                          (min_ones_q == 4'd0) ? DigitMax : min_ones_q - 4'd1;
    assign dec_min_tens = borrow_mt ? min_tens_q - 4'd1 : min_tens_q;
    assign dec_zero     = (dec_sec_ones == 4'd0) && (dec_sec_tens == 4'd0) &&
                          (dec_min_ones == 4'd0) && (dec_min_tens == 4'd0);

    always_ff @(posedge clock_100Hz) begin
        if (reset) begin
            p_q        <= 1'b1;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            done_q     <= 1'b0;
        end else begin
            p_q    <= bus.pgt_1Hz;
            done_q <= 1'b0;
            if (!bus.clear_n) begin
                sec_ones_q <= 4'd0;
                sec_tens_q <= 4'd0;
                min_ones_q <= 4'd0;
                min_tens_q <= 4'd0;
            end else if (tick) begin
                if (!bus.enable_n) begin
                    if (load_ok) begin
                        min_tens_q <= min_ones_q;
                        min_ones_q <= sec_tens_q;
                        sec_tens_q <= sec_ones_q;
                        sec_ones_q <= bus.D;
                    end
                end else if (!zero) begin
                    sec_ones_q <= dec_sec_ones;
                    sec_tens_q <= dec_sec_tens;
                    min_ones_q <= dec_min_ones;
                    min_tens_q <= dec_min_tens;
                    done_q     <= dec_zero;
                end
            end
        end
    end

    assign bus.sec_ones = sec_ones_q;
    assign bus.sec_tens = sec_tens_q;
    assign bus.min_ones = min_ones_q;
    assign bus.min_tens = min_tens_q;
    assign bus.zero     = zero;
    assign bus.done     = done_q;
endmodule
